uart_frame_tx: RTL and testbench
================================

// Module: uart_frame_tx
// PURPOSE
// - Command-frame initiator: the sending end of the 18-byte UART command protocol decoded on the ECP5 coprocessor.
// - Takes an 8-bit command and a 128-bit payload and builds the frame {cmd, payload[127:0], cmd}.
// - Serialises the frame as 8N1 on a single tx line; drives the coprocessor rx pin (loopback/host-emulation side).
// PARAMETERS
// CLK_FREQ     103_340_000  system clock in Hz
// BAUD         115_200      line rate in bit/s
// DBITS        8            data bits per UART character
// FRAME_BYTES  18           characters per frame: 1 header + 16 payload + 1 trailer
// BAUD_DIV     (CLK_FREQ+BAUD/2)/BAUD  cycles per bit, derived (localparam); 897 at default
// PORTS
// clk        in   1    system clock, all logic on posedge
// reset_n    in   1    synchronous, active-low reset
// cmd_valid  in   1    request to send a frame
// cmd_ready  out  1    block can accept a frame this cycle
// cmd        in   8    command character, sent as first and last byte
// payload    in   128  payload; payload[127:120] is sent first
// tx         out  1    serial line, idle high
// busy       out  1    frame in progress
// done       out  1    one-cycle pulse when the final stop bit completes
// BEHAVIOUR
// - Reset (reset_n=0 at posedge): tx=1, busy=0, done=0, cmd_ready=1 after reset releases. State=IDLE, all counters 0.
// - Reset mid-frame: the frame is discarded and tx=1 on the next cycle. No done pulse is generated.
// - Handshake: transfer when cmd_valid & cmd_ready. cmd_ready=1 only in IDLE. The frame is latched into a 144-bit
//   shift register {cmd,payload,cmd} on that edge. cmd/payload may change freely afterwards.
//   cmd_valid while busy is ignored; a request is never queued.
// - FSM: IDLE -> START -> DATA -> STOP -> (byte_idx==17 ? IDLE : START).
//   - START: tx=0 for BAUD_DIV cycles.
//   - DATA: DBITS bits, LSB first, each held for BAUD_DIV cycles.
//   - STOP: tx=1 for BAUD_DIV cycles. byte_idx increments at the end of STOP.
//   - byte_idx runs 0..17 and resets to 0 on entry to IDLE.
// - Latency: tx falls exactly 1 cycle after the accepting edge.
//   Whole frame = FRAME_BYTES*(DBITS+2)*BAUD_DIV cycles = 180*BAUD_DIV.
// - Bit timer counts 0..BAUD_DIV-1 and wraps. No gaps between characters: the next START immediately follows STOP.
// - done=1 in the cycle the FSM re-enters IDLE. In that same cycle busy=0 and cmd_ready=1, so back-to-back frames
//   lose no more than 1 idle-high cycle.
// - busy = (state != IDLE). tx is registered (glitch-free). No combinational path from inputs to tx.
// - Byte order matches the receiver: the receiver sees frame[143:136]=cmd, frame[135:8]=payload, frame[7:0]=cmd.
// - BAUD_DIV < 2 is illegal; the block stops at elaboration (generate-time $error).
// STRUCTURE
// - Shared header uart_frame_defs.vh holds: DBITS, FRAME_BYTES, PAYLOAD_W=128, FRAME_W=FRAME_BYTES*DBITS,
//   and the state encodings (S_IDLE, S_START, S_DATA, S_STOP). The receiver-side decoder uses the same header.
// - One sub-module, uart_tx_byte: a baud timer plus 8N1 serialiser with byte_valid/byte_ready/byte_done.
//   uart_frame_tx itself holds the frame shift register, byte_idx, and the handshake.
//   An inline, flat FSM is also acceptable if the timing above is identical.
// TESTING (bench CLK_FREQ=1_000_000, BAUD=100_000 -> BAUD_DIV=10)
// 1. Reset: hold reset_n=0 for 5 cycles, then release -> tx=1, busy=0, done=0, cmd_ready=1.
// 2. Single frame cmd="A", payload=128'h000102..0F -> tx falls 1 cycle after accept. Decoded bytes are
//    41,00,01,..,0F,41. done pulses exactly 1800 cycles after accept.
// 3. Back-to-back: cmd_valid held high with cmd="C" then "D" -> the second start bit begins at most 2 cycles after
//    the first done. Both frames decode correctly.
// 4. cmd_valid pulsed with cmd="E" 500 cycles into a frame -> ignored. The current frame is unaltered.
//    Exactly one done pulse.
// 5. reset_n=0 for 1 cycle at cycle 700 of a frame -> next cycle tx=1, busy=0, cmd_ready=1. No done pulse.
//    A subsequent frame sends cleanly.
// 6. Loopback into the coprocessor receiver: send "C" with key 2b7e1516..., "D" with plaintext, "E", then "B"
//    -> the receiver latches key/plaintext identically and the header byte equals the trailer byte in every frame.

Source files
------------

// File: rtl/uart_frame_tx_pkg.sv
// Shared frame geometry, serialiser state encoding and baud divider helper.
package uart_frame_tx_pkg;

    localparam int DBITS       = 8;
    localparam int FRAME_BYTES = 18;
    localparam int PAYLOAD_W   = 128;
    localparam int FRAME_W     = FRAME_BYTES * DBITS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

    // Cycles per bit, rounded to nearest.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_frame_tx_byte.sv
// 8N1 character serialiser with its own baud timer.
// Latency: tx drops to the start bit on the edge that takes a byte.
// Backpressure: byte_ready in IDLE or on the last stop-bit cycle, so characters chain with no gap.
module uart_frame_tx_byte
    import uart_frame_tx_pkg::*;
#(
    parameter int BAUD_DIV = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             byte_valid,
    output logic             byte_ready,
    input  logic [DBITS-1:0] byte_dat,
    output logic             byte_done,
    output logic             tx
);

    localparam int CW = (BAUD_DIV < 2) ? 1 : $clog2(BAUD_DIV);
    localparam int BW = $clog2(DBITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DBITS - 1);

    tx_state_t        state;
    logic [CW-1:0]    cnt;
    logic [BW-1:0]    bit_idx;
    logic [DBITS-1:0] sh;
    logic             bit_end;

    assign bit_end    = (cnt == CNT_LAST);
    assign byte_done  = (state == S_STOP) && bit_end;
    assign byte_ready = (state == S_IDLE) || byte_done;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            sh      <= '0;
            tx      <= 1'b1;
        end else if (byte_valid && byte_ready) begin
            state   <= S_START;
            cnt     <= '0;
            bit_idx <= '0;
            sh      <= byte_dat;
            tx      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    tx  <= 1'b1;
                end
                S_START, S_DATA, S_STOP: begin
                    if (!bit_end) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        if (state == S_STOP) begin
                            state <= S_IDLE;
                            tx    <= 1'b1;
                        end else if (state == S_DATA && bit_idx == BIT_LAST) begin
                            state <= S_STOP;
                            tx    <= 1'b1;
                        end else begin
                            // LSB first: shift the next data bit onto the line.
                            if (state == S_DATA) bit_idx <= bit_idx + 1'b1;
                            state <= S_DATA;
                            tx    <= sh[0];
                            sh    <= {1'b0, sh[DBITS-1:1]};
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_frame_tx.sv
// Builds {cmd, payload, cmd} and sends it as 18 back-to-back 8N1 characters.
// Latency: tx falls 1 cycle after accept; done pulses 180*BAUD_DIV cycles after accept.
// Backpressure: cmd_ready only while idle; requests during a frame are dropped, never queued.
module uart_frame_tx
    import uart_frame_tx_pkg::*;
#(
    parameter int CLK_FREQ = 103_340_000,
    parameter int BAUD     = 115_200
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [DBITS-1:0]     cmd,
    input  logic [PAYLOAD_W-1:0] payload,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
    localparam int IW       = $clog2(FRAME_BYTES);
    localparam logic [IW-1:0] IDX_LAST = IW'(FRAME_BYTES - 1);

    if (BAUD_DIV < 2) begin : g_bad_baud
        $error("uart_frame_tx: BAUD_DIV must be at least 2");
    end

    logic               active;
    logic [IW-1:0]      byte_idx;
    logic [FRAME_W-1:0] frame_sr;
    logic               accept;
    logic               last_byte;
    logic               byte_valid;
    logic               byte_ready;
    logic               byte_done;
    logic [DBITS-1:0]   byte_dat;

    assign cmd_ready  = !active;
    assign busy       = active;
    assign accept     = cmd_valid && cmd_ready;
    assign last_byte  = (byte_idx == IDX_LAST);
    assign byte_valid = accept || (active && !last_byte);
    // The header goes straight from the port so tx can fall on the accepting edge.
    assign byte_dat   = active ? frame_sr[FRAME_W-1 -: DBITS] : cmd;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            active   <= 1'b0;
            byte_idx <= '0;
            frame_sr <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                active   <= 1'b1;
                byte_idx <= '0;
                frame_sr <= {payload, cmd, {DBITS{1'b0}}};
            end else if (active && byte_done) begin
                if (last_byte) begin
                    active   <= 1'b0;
                    byte_idx <= '0;
                    done     <= 1'b1;
                end else begin
                    byte_idx <= byte_idx + 1'b1;
                    frame_sr <= frame_sr << DBITS;
                end
            end
        end
    end

    uart_frame_tx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_byte (
        .clk        (clk),
        .reset_n    (reset_n),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_dat   (byte_dat),
        .byte_done  (byte_done),
        .tx         (tx)
    );

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed stimulus with a byte/done scoreboard fed by a line-level UART monitor.
module tb_uart_frame_tx;

    localparam int DIV   = 10;
    localparam int FRAME = 180 * DIV;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [7:0]   cmd;
    logic [127:0] payload;
    logic         tx;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_acc = 0;

    logic [7:0] exp_q[$];
    int         done_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_frame_tx #(
        .CLK_FREQ (1_000_000),
        .BAUD     (100_000)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd       (cmd),
        .payload   (payload),
        .tx        (tx),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Called at posedge+2; returns at posedge+2 after the accepting edge with cmd_valid still high.
    task automatic send(input logic [7:0] c, input logic [127:0] p);
        int n;
        cmd       = c;
        payload   = p;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 4000) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (!cmd_ready) begin
            fail_now("send_timeout");
            return;
        end
        @(posedge clk);
        #1;
        last_acc = cyc;
        exp_q.push_back(c);
        for (int i = 15; i >= 0; i--) exp_q.push_back(p[i*8 +: 8]);
        exp_q.push_back(c);
        done_q.push_back(last_acc + FRAME);
        check("tx_fall_after_accept", tx, 1'b0);
        check("busy_after_accept", busy, 1'b1);
        #1;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (done !== 1'b1 && n < 4000);
        if (done !== 1'b1) begin
            fail_now("done_timeout");
        end else begin
            check("busy_at_done", busy, 1'b0);
            check("ready_at_done", cmd_ready, 1'b1);
        end
        #1;
    endtask

    // Line monitor: decodes 8N1 mid-bit and scores bytes and done pulses.
    bit         rx_on = 0;
    int         rx_k  = 0;
    logic [7:0] rx_sh = '0;

    always @(negedge clk) begin
        if (reset_n !== 1'b1) begin
            rx_on = 0;
        end else if (!rx_on) begin
            if (tx === 1'b0) begin
                rx_on = 1;
                rx_k  = 0;
            end
        end else begin
            rx_k++;
            if (rx_k == 5) begin
                check("start_bit", tx, 1'b0);
            end else if (rx_k >= 15 && rx_k <= 85 && (rx_k - 15) % 10 == 0) begin
                rx_sh = {tx, rx_sh[7:1]};
            end else if (rx_k == 95) begin
                check("stop_bit", tx, 1'b1);
                if (exp_q.size() == 0) fail_now("unexpected_byte");
                else check("rx_byte", rx_sh, exp_q.pop_front());
                rx_on = 0;
            end
        end
        if (done === 1'b1) begin
            if (done_q.size() == 0) fail_now("unexpected_done");
            else check("done_cycle", cyc, done_q.pop_front());
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a_c, a_d;
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd       = '0;
        payload   = '0;

        // Reset
        repeat (5) @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_tx", tx, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_ready", cmd_ready, 1'b1);
        #1;

        // Single frame
        send(8'h41, 128'h000102030405060708090a0b0c0d0e0f);
        cmd_valid = 1'b0;
        wait_done();

        // Back-to-back with cmd_valid held high
        send(8'h43, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
        a_c = last_acc;
        send(8'h44, 128'h8000_0000_0000_0000_0000_0000_0000_0001);
        a_d = last_acc;
        cmd_valid = 1'b0;
        check("b2b_gap", a_d - a_c, FRAME + 1);
        wait_done();

        // Request mid-frame is ignored
        send(8'h5a, 128'hdead_beef_cafe_f00d_0123_4567_89ab_cdef);
        cmd_valid = 1'b0;
        repeat (500) @(posedge clk);
        #2;
        check("ready_while_busy", cmd_ready, 1'b0);
        cmd       = 8'h45;
        payload   = '1;
        cmd_valid = 1'b1;
        @(posedge clk);
        #2 cmd_valid = 1'b0;
        wait_done();

        // Reset mid-frame
        send(8'h52, 128'hffee_ddcc_bbaa_9988_7766_5544_3322_1100);
        cmd_valid = 1'b0;
        repeat (700) @(posedge clk);
        #2;
        exp_q.delete();
        done_q.delete();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_tx", tx, 1'b1);
        check("midreset_busy", busy, 1'b0);
        check("midreset_ready", cmd_ready, 1'b1);
        check("midreset_done", done, 1'b0);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #2;
        send(8'h53, 128'h0f0e0d0c0b0a09080706050403020100);
        cmd_valid = 1'b0;
        wait_done();

        // Coprocessor command sequence
        send(8'h43, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        send(8'h44, 128'h3243f6a8885a308d313198a2e0370734);
        send(8'h45, 128'h0);
        send(8'h42, 128'h0);
        cmd_valid = 1'b0;
        wait_done();

        repeat (20) @(posedge clk);
        #2;
        check("bytes_drained", exp_q.size(), 0);
        check("dones_drained", done_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
